trng_byte_reader: RTL
=====================

TRNG_BYTE_READER -- requirements
Module: trng_byte_reader

Interface
- REQ-001 SHALL have parameter FIFO_DEPTH, default 4: output FIFO depth in bytes (power of two, 2..16).
- REQ-002 SHALL have parameter RCT_LIMIT, default 32: repetition-count test cutoff, counted in consecutive identical raw bits (2..255).
- REQ-003 SHALL have port: clk  input  1  sole clock, rising edge.
- REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port: start  input  1  level enable; collection runs while high.
- REQ-006 SHALL have port: raw_bit  input  1  raw entropy bit from the TRNG core.
- REQ-007 SHALL have port: raw_valid  input  1  raw_bit is sampled on any clk edge where this is high.
- REQ-008 SHALL have port: out_data  output  8  byte at the FIFO head.
- REQ-009 SHALL have port: out_valid  output  1  FIFO non-empty.
- REQ-010 SHALL have port: out_ready  input  1  consumer accepts out_data.
- REQ-011 SHALL have port: fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored bytes.
- REQ-012 SHALL have port: overflow  output  1  sticky flag: at least one byte has been dropped.
- REQ-013 SHALL have port: health_fail  output  1  repetition-count test has tripped.

Function
- REQ-014 SHALL implement the FSM states IDLE, COLLECT and FAIL. IDLE->COLLECT on start=1; COLLECT->IDLE on start=0; COLLECT->FAIL on an RCT trip; FAIL->IDLE on start=0.
- REQ-015 SHALL sample raw bits only in COLLECT, and only on cycles where raw_valid=1.
- REQ-016 SHALL debias with von Neumann pairing: the first sampled bit is held; on the second sampled bit, the pair emits the first bit if the two bits differ, and emits nothing if they are equal.
- REQ-017 SHALL assemble debiased bits MSB first: the first emitted bit becomes out_data[7] of that byte.
- REQ-018 SHALL push a byte into the FIFO on the clk edge that samples the raw bit completing its 8th debiased bit; out_valid SHALL rise on that same edge if the FIFO was empty.
- REQ-019 SHALL drive out_valid = (fifo_count != 0) from registers, and SHALL pop the FIFO on any edge where out_valid & out_ready.
- REQ-020 SHALL, on a push while full with no pop, drop the new byte and set overflow; overflow is cleared only by rst.
- REQ-021 SHALL, on a simultaneous push and pop while full, accept the push with fifo_count unchanged and overflow not set.
- REQ-022 SHALL, on a simultaneous push and pop at any other count, keep fifo_count unchanged.
- REQ-023 SHALL use wrap-around read and write pointers modulo FIFO_DEPTH.
- REQ-024 SHALL, on leaving COLLECT for IDLE, discard any pending pair bit and partial byte, and SHALL retain the FIFO contents.
- REQ-025 SHALL, while in IDLE, continue to allow FIFO pops.
- REQ-026 SHALL, on entering FAIL, flush the FIFO (fifo_count=0, out_valid=0) and discard the partial byte.
- REQ-027 SHALL assert health_fail in FAIL and clear it on FAIL->IDLE.
- REQ-028 SHALL ignore out_ready while in FAIL.

Reset
- REQ-029 SHALL, on rst=1, asynchronously force: state=IDLE, out_data=8'h00, out_valid=0, fifo_count=0, overflow=0, health_fail=0, RCT counter=0, FIFO pointers=0, and the pair and partial-byte registers cleared.
- REQ-030 SHALL abort any operation in progress on reset assertion mid-operation, with no output glitches other than the forced values.

Configuration
- REQ-031 With TRNG_HEALTH_EN defined: SHALL count consecutive identical sampled raw bits (counter restarts at 1 whenever the bit value changes) and trip on the sample that brings the count to RCT_LIMIT; FAIL SHALL be entered and health_fail SHALL rise on that same edge.
- REQ-032 Without TRNG_HEALTH_EN: SHALL omit the RCT counter, tie health_fail to 0, and make FAIL unreachable; all other behaviour SHALL be identical.

Verification
- REQ-033 After rst, start=1, raw pairs (1,0),(0,1) alternating x4 -> one push; out_data=8'hAA, out_valid=1, fifo_count=1.
- REQ-034 Pairs (1,1),(0,0) interleaved with eight (0,1) pairs -> equal pairs discarded; out_data=8'h00, exactly one byte produced.
- REQ-035 out_ready=0, five 8'hFF bytes produced (eight (1,0) pairs each) -> fifo_count=4 and overflow=1; then out_ready=1 drains exactly four 8'hFF bytes, after which out_valid=0 and overflow stays 1.
- REQ-036 TRNG_HEALTH_EN defined, RCT_LIMIT=32, 32 consecutive raw 1s with FIFO holding 2 bytes -> health_fail=1 and fifo_count=0 on the 32nd sample edge; start=0 -> health_fail=0 next edge. Without the macro: no trip.
- REQ-037 start dropped after 5 debiased bits, then raised again, then eight (0,1) pairs -> out_data=8'h00 (stale partial byte discarded).
- REQ-038 rst pulsed mid-byte with fifo_count=3 -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/trng_byte_reader.sv
// trng_byte_reader: von Neumann debiased TRNG bit collector feeding a byte FIFO.
// Define TRNG_HEALTH_EN to enable the repetition-count health test and the FAIL state.
module trng_byte_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int RCT_LIMIT  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          raw_bit,
    input  logic                          raw_valid,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          health_fail
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, FAIL} state_t;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        RCT_LIMIT < 2 || RCT_LIMIT > 255) begin : g_bad_param
        $error("trng_byte_reader: parameter out of range");
    end

    state_t          state_q;
    logic            pair_q, pbit_q;
    logic [6:0]      acc_q;
    logic [2:0]      nbits_q;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   count_q;
    logic            ovf_q;
    logic            sample, emit, push, pop, full, accept, trip;

    assign sample = state_q == COLLECT && start && raw_valid;
    assign emit   = sample && pair_q && raw_bit != pbit_q;
    assign push   = emit && nbits_q == 3'd7 && !trip;
    assign pop    = count_q != '0 && out_ready && state_q != FAIL;
    assign full   = count_q == CW'(FIFO_DEPTH);
    assign accept = push && (!full || pop);

`ifdef TRNG_HEALTH_EN
    logic [7:0] rct_q, rct_d;
    logic       rct_bit_q;
    // Run length restarts at 1 on any change of value (or on the first sample).
    assign rct_d = (rct_q != 8'd0 && raw_bit == rct_bit_q) ? rct_q + 8'd1 : 8'd1;
    assign trip  = sample && rct_d == 8'(RCT_LIMIT);
    assign health_fail = state_q == FAIL;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rct_q     <= 8'd0;
            rct_bit_q <= 1'b0;
        end else if (trip || (state_q != COLLECT)) begin
            rct_q     <= 8'd0;
        end else if (sample) begin
            rct_q     <= rct_d;
            rct_bit_q <= raw_bit;
        end
    end
`else
    assign trip        = 1'b0;
    assign health_fail = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pair_q  <= 1'b0;
            pbit_q  <= 1'b0;
            acc_q   <= '0;
            nbits_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (trip) begin
            state_q <= FAIL;
            pair_q  <= 1'b0;
            acc_q   <= '0;
            nbits_q <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (state_q == IDLE && start)
                state_q <= COLLECT;
            else if (state_q != IDLE && !start)
                state_q <= IDLE;
            if (state_q == COLLECT && !start) begin
                pair_q  <= 1'b0;
                acc_q   <= '0;
                nbits_q <= '0;
            end else if (sample) begin
                pair_q <= !pair_q;
                if (!pair_q)
                    pbit_q <= raw_bit;
                if (emit) begin
                    nbits_q <= nbits_q + 3'd1;
                    acc_q   <= {acc_q[5:0], pbit_q};
                end
            end
            if (accept)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(accept) - CW'(pop);
            if (push && full && !pop)
                ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_q] <= {acc_q, pbit_q};
    end

    // Gate the head with the count so an empty or flushed FIFO always reads 0.
    assign out_data   = count_q != '0 ? mem[rd_q] : 8'h00;
    assign out_valid  = count_q != '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
endmodule
